// File: rtl/fwd_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// fwd_pkg: shared select encoding and priority helper for forwarding. Rev 1.0
// ------------------------------------------------------------------------
package fwd_pkg;

  localparam int SEL_RF         = 0;
  localparam int SEL_STAGE_BASE = 1;
  localparam int MAX_SEL_W      = 32;

  // Isolates the lowest set bit; the lowest stage index is the youngest result.
  function automatic logic [MAX_SEL_W-1:0] onehot_first(input logic [MAX_SEL_W-1:0] req);
    return req & (~req + 1'b1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_onehot_mux.sv
`default_nettype none
// ------------------------------------------------------------------------
// fwd_onehot_mux: AND-OR multiplexer driven by a one-hot select. Rev 1.0
// ------------------------------------------------------------------------
module fwd_onehot_mux #(
  parameter int DATA_W = 8,
  parameter int N      = 3
) (
  input  logic [N-1:0]        sel,
  input  logic [N*DATA_W-1:0] data_in,
  output logic [DATA_W-1:0]   data_out
);

  always_comb begin
    data_out = '0;
    for (int n = 0; n < N; n++) begin
      data_out = data_out | (data_in[n*DATA_W +: DATA_W] & {DATA_W{sel[n]}});
    end
  end

endmodule
`default_nettype wire

// File: rtl/fwd_operand_unit.sv
`default_nettype none
// ------------------------------------------------------------------------
// fwd_operand_unit: EX-stage forwarding selects, operand mux and load-use stall. Rev 1.0
// ------------------------------------------------------------------------
module fwd_operand_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int NUM_OPS  = 2,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         advance,
  input  logic                         flush,
  input  logic [NUM_OPS*ADDR_W-1:0]    id_src_addr,
  input  logic [ADDR_W-1:0]            id_dst_addr,
  input  logic                         id_wr_en,
  input  logic                         id_is_load,
  input  logic [NUM_OPS*DATA_W-1:0]    ex_rf_data,
  input  logic [DEPTH*DATA_W-1:0]      stage_data,
  output logic [NUM_OPS*DATA_W-1:0]    operand_out,
  output logic [NUM_OPS*(DEPTH+1)-1:0] operand_sel,
  output logic                         stall,
  output logic [15:0]                  stall_count
);

  localparam int SEL_W = DEPTH + 1;

  logic                             ex_valid;
  logic                             ex_load;
  logic [ADDR_W-1:0]                ex_dst;
  logic [NUM_OPS-1:0][ADDR_W-1:0]   ex_src;
  logic [DEPTH-1:0]                 sb_valid;
  logic [DEPTH-1:0]                 sb_load;
  logic [DEPTH-1:0][ADDR_W-1:0]     sb_dst;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid    <= 1'b0;
      ex_load     <= 1'b0;
      ex_dst      <= '0;
      ex_src      <= '0;
      sb_valid    <= '0;
      sb_load     <= '0;
      sb_dst      <= '0;
      stall_count <= '0;
    end else begin
      if (advance) begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          sb_valid[k] <= sb_valid[k-1];
          sb_load[k]  <= sb_load[k-1];
          sb_dst[k]   <= sb_dst[k-1];
        end
        sb_valid[0] <= ex_valid;
        sb_load[0]  <= ex_load;
        sb_dst[0]   <= ex_dst;
        if (stall || flush) begin
          ex_valid <= 1'b0;
          ex_load  <= 1'b0;
          ex_dst   <= '0;
          ex_src   <= '0;
        end else begin
          ex_valid <= id_wr_en;
          ex_load  <= id_is_load;
          ex_dst   <= id_dst_addr;
          ex_src   <= id_src_addr;
        end
      end else if (flush) begin
        ex_valid <= 1'b0;
        ex_load  <= 1'b0;
        ex_dst   <= '0;
        ex_src   <= '0;
      end
      if (stall && advance && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

  // Loads younger than LOAD_LAT cannot supply data yet, so the consumer waits in ID.
  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (id_src_addr[i*ADDR_W +: ADDR_W] != '0) begin
        if (ex_valid && ex_load && (ex_dst == id_src_addr[i*ADDR_W +: ADDR_W])) begin
          stall = 1'b1;
        end
        for (int k = 0; k < LOAD_LAT - 1; k++) begin
          if (sb_valid[k] && sb_load[k] && (sb_dst[k] == id_src_addr[i*ADDR_W +: ADDR_W])) begin
            stall = 1'b1;
          end
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
      logic [DEPTH-1:0] hit;
      logic [DEPTH-1:0] grant;
      logic [SEL_W-1:0] sel;

      always_comb begin
        hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
          hit[k] = sb_valid[k] && (sb_dst[k] == ex_src[i]) && (ex_src[i] != '0) &&
                   (!sb_load[k] || (k >= LOAD_LAT));
        end
      end

      assign grant = DEPTH'(onehot_first(MAX_SEL_W'(hit)));

      always_comb begin
        sel = '0;
        if (|hit) begin
          sel[SEL_STAGE_BASE +: DEPTH] = grant;
        end else begin
          sel[SEL_RF] = 1'b1;
        end
      end

      assign operand_sel[i*SEL_W +: SEL_W] = sel;

      fwd_onehot_mux #(
        .DATA_W (DATA_W),
        .N      (SEL_W)
      ) u_mux (
        .sel      (sel),
        .data_in  ({stage_data, ex_rf_data[i*DATA_W +: DATA_W]}),
        .data_out (operand_out[i*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fwd_operand_unit.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_fwd_operand_unit: directed vector table plus async-reset-during-stall sequence. Rev 1.0
// ------------------------------------------------------------------------
module tb_fwd_operand_unit;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 5;
  localparam int NUM_OPS  = 2;
  localparam int DEPTH    = 2;
  localparam int LOAD_LAT = 1;
  localparam int NV       = 26;

  logic                         clock = 1'b0;
  logic                         reset_n = 1'b0;
  logic                         advance = 1'b0;
  logic                         flush = 1'b0;
  logic [NUM_OPS*ADDR_W-1:0]    id_src_addr = '0;
  logic [ADDR_W-1:0]            id_dst_addr = '0;
  logic                         id_wr_en = 1'b0;
  logic                         id_is_load = 1'b0;
  logic [NUM_OPS*DATA_W-1:0]    ex_rf_data = 16'h1122;
  logic [DEPTH*DATA_W-1:0]      stage_data = 16'h02A5;
  logic [NUM_OPS*DATA_W-1:0]    operand_out;
  logic [NUM_OPS*(DEPTH+1)-1:0] operand_sel;
  logic                         stall;
  logic [15:0]                  stall_count;

  int compared = 0;
  int failed   = 0;

  fwd_operand_unit #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_OPS  (NUM_OPS),
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .advance     (advance),
    .flush       (flush),
    .id_src_addr (id_src_addr),
    .id_dst_addr (id_dst_addr),
    .id_wr_en    (id_wr_en),
    .id_is_load  (id_is_load),
    .ex_rf_data  (ex_rf_data),
    .stage_data  (stage_data),
    .operand_out (operand_out),
    .operand_sel (operand_sel),
    .stall       (stall),
    .stall_count (stall_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        adv;
    logic        fl;
    logic [4:0]  s0;
    logic [4:0]  s1;
    logic [4:0]  dst;
    logic        wr;
    logic        ld;
    logic [15:0] sd;
    logic [15:0] out;   // {op1, op0}
    logic [5:0]  sel;   // {sel1, sel0}
    logic        stl;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(logic adv, logic fl, logic [4:0] s0, logic [4:0] s1,
                              logic [4:0] dst, logic wr, logic ld, logic [15:0] sd,
                              logic [15:0] out, logic [5:0] sel, logic stl, logic [15:0] cnt);
    vec_t v;
    v.adv = adv; v.fl = fl; v.s0 = s0; v.s1 = s1; v.dst = dst; v.wr = wr; v.ld = ld;
    v.sd = sd; v.out = out; v.sel = sel; v.stl = stl; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    //             adv fl  s0 s1 dst wr ld  sd        out       sel        stl cnt
    vecs[0]  = mk(1, 0, 0, 0, 3, 1, 0, 16'h02A5, 16'h1122, 6'b001001, 0, 0); // write r3
    vecs[1]  = mk(1, 0, 3, 0, 0, 0, 0, 16'h02A5, 16'h1122, 6'b001001, 0, 0); // read r3
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 16'h02A5, 16'h11A5, 6'b001010, 0, 0); // EX/MEM fwd
    vecs[3]  = mk(1, 0, 0, 0, 4, 1, 0, 16'h02A5, 16'h11A5, 6'b001010, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 4, 1, 0, 16'h0201, 16'h1122, 6'b001001, 0, 0);
    vecs[5]  = mk(1, 0, 4, 4, 0, 0, 0, 16'h0201, 16'h1122, 6'b001001, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 16'h0201, 16'h0101, 6'b010010, 0, 0); // youngest wins
    vecs[7]  = mk(1, 0, 0, 0, 4, 1, 0, 16'h0201, 16'h0101, 6'b010010, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0, 0, 0, 0, 16'h0201, 16'h1122, 6'b001001, 0, 0); // bubble
    vecs[9]  = mk(1, 0, 4, 0, 0, 0, 0, 16'h0201, 16'h1122, 6'b001001, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 16'h0201, 16'h1102, 6'b001100, 0, 0); // MEM/WB fwd
    vecs[11] = mk(1, 0, 0, 0, 0, 1, 0, 16'h0201, 16'h1102, 6'b001100, 0, 0); // write r0
    vecs[12] = mk(1, 0, 0, 0, 0, 0, 0, 16'h0201, 16'h1122, 6'b001001, 0, 0); // read r0
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 16'h0201, 16'h1122, 6'b001001, 0, 0);
    vecs[14] = mk(1, 0, 0, 0, 5, 1, 1, 16'h0201, 16'h1122, 6'b001001, 0, 0); // load r5
    vecs[15] = mk(1, 0, 5, 0, 0, 0, 0, 16'h0201, 16'h1122, 6'b001001, 1, 0); // load-use
    vecs[16] = mk(1, 0, 5, 0, 0, 0, 0, 16'h0201, 16'h1122, 6'b001001, 0, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 16'h0201, 16'h1102, 6'b001100, 0, 1); // load data fwd
    vecs[18] = mk(1, 0, 0, 0, 6, 1, 1, 16'h0201, 16'h1102, 6'b001100, 0, 1); // load r6
    vecs[19] = mk(1, 1, 6, 6, 0, 0, 0, 16'h0201, 16'h1122, 6'b001001, 1, 1); // flush+stall
    vecs[20] = mk(1, 0, 0, 0, 7, 1, 0, 16'h0201, 16'h1122, 6'b001001, 0, 2);
    vecs[21] = mk(1, 1, 7, 0, 0, 0, 0, 16'h0201, 16'h1122, 6'b001001, 0, 2); // flush reader
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 16'h0201, 16'h1122, 6'b001001, 0, 2);
    vecs[23] = mk(1, 0, 7, 0, 0, 0, 0, 16'h0201, 16'h1122, 6'b001001, 0, 2);
    vecs[24] = mk(0, 1, 0, 0, 0, 0, 0, 16'h0201, 16'h1102, 6'b001100, 0, 2); // flush, no adv
    vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 16'h0201, 16'h1122, 6'b001001, 0, 2);

    // Reset state
    #1;
    chk("reset operand_out", operand_out, 16'h1122);
    chk("reset operand_sel", 16'(operand_sel), 16'h0009);
    chk("reset stall", 16'(stall), 16'h0000);
    chk("reset stall_count", stall_count, 16'h0000);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    for (int r = 0; r < NV; r++) begin
      @(negedge clock);
      advance     = vecs[r].adv;
      flush       = vecs[r].fl;
      id_src_addr = {vecs[r].s1, vecs[r].s0};
      id_dst_addr = vecs[r].dst;
      id_wr_en    = vecs[r].wr;
      id_is_load  = vecs[r].ld;
      stage_data  = vecs[r].sd;
      #1;
      chk($sformatf("vec%0d operand_out", r), operand_out, vecs[r].out);
      chk($sformatf("vec%0d operand_sel", r), 16'(operand_sel), 16'(vecs[r].sel));
      chk($sformatf("vec%0d stall", r), 16'(stall), 16'(vecs[r].stl));
      chk($sformatf("vec%0d stall_count", r), stall_count, vecs[r].cnt);
    end

    // Load into EX, then a dependent reader held in ID with the pipeline frozen
    @(negedge clock);
    advance = 1'b1; flush = 1'b0;
    id_src_addr = '0; id_dst_addr = 5'd9; id_wr_en = 1'b1; id_is_load = 1'b1;
    @(negedge clock);
    advance = 1'b0;
    id_src_addr = {5'd0, 5'd9}; id_dst_addr = '0; id_wr_en = 1'b0; id_is_load = 1'b0;
    #1;
    chk("midstall stall", 16'(stall), 16'h0001);
    @(negedge clock);
    #1;
    chk("held stall", 16'(stall), 16'h0001);
    chk("held stall_count", stall_count, 16'h0002);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async reset stall", 16'(stall), 16'h0000);
    chk("async reset operand_sel", 16'(operand_sel), 16'h0009);
    chk("async reset operand_out", operand_out, 16'h1122);
    chk("async reset stall_count", stall_count, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
`default_nettype wire
